// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle for fetch_sequencer: instruction-memory request/ack,
// decode valid/ready, and the retire/branch-resolution result.
interface fetch_sequencer_if #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32
);
  logic                 halt;
  logic                 imem_req;
  logic [WORD-1:0]      imem_addr;
  logic                 imem_ack;
  logic [INSTR_LEN-1:0] imem_rdata;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [INSTR_LEN-1:0] instruction;
  logic [WORD-1:0]      cur_pc;
  logic                 retire;
  logic                 pc_src;
  logic [WORD-1:0]      branch_target;
  logic                 align_err;
  logic                 halted;

  // Handshakes: a transfer happens on a rising clk edge where both sides are
  // high (imem_req&imem_ack, instr_valid&instr_ready). The producer keeps
  // valid/req and its payload stable until that edge; ack/ready/retire seen
  // outside the state that waits for them are ignored.
  modport master (
    input  halt, imem_ack, imem_rdata, instr_ready, retire, pc_src, branch_target,
    output imem_req, imem_addr, instr_valid, instruction, cur_pc, align_err, halted
  );

  modport slave (
    output halt, imem_ack, imem_rdata, instr_ready, retire, pc_src, branch_target,
    input  imem_req, imem_addr, instr_valid, instruction, cur_pc, align_err, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner and fetch sequencer for the nonpipelined LEGv8 core: REQ -> HOLD -> EXEC.
// Optional macro FETCH_PERF_EN adds fetch_count / stall_cycles counters.
module fetch_sequencer #(
  parameter int              WORD      = 64,
  parameter int              INSTR_LEN = 32,
  parameter logic [WORD-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                reset,
  fetch_sequencer_if.master   bus,
  output logic [2:0]          state_dbg
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [31:0]         stall_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    HOLD   = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [WORD-1:0]      pc_q;
  logic [INSTR_LEN-1:0] instr_q;
  logic                 align_q;

  logic [WORD-1:0]      seq_pc;
  logic [WORD-1:0]      redirect_pc;
  logic                 retire_fire;
  logic                 misaligned;

  // Sequential PC wraps naturally modulo 2^WORD; redirects drop the low bits.
  assign seq_pc      = pc_q + WORD'(4);
  assign redirect_pc = {bus.branch_target[WORD-1:2], 2'b00};
  assign retire_fire = (state_q == EXEC) && bus.retire;
  assign misaligned  = bus.pc_src && (bus.branch_target[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.halt ? HALTED : REQ;
      REQ:     if (bus.imem_ack) state_d = HOLD;
      HOLD:    if (bus.instr_ready) state_d = EXEC;
      EXEC:    if (bus.retire) state_d = bus.halt ? HALTED : REQ;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == REQ) && bus.imem_ack) instr_q <= bus.imem_rdata;
      if (retire_fire) pc_q <= bus.pc_src ? redirect_pc : seq_pc;
      align_q <= retire_fire && misaligned;
    end
  end

  assign bus.imem_req    = (state_q == REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instruction = instr_q;
  assign bus.cur_pc      = pc_q;
  assign bus.align_err   = align_q;
  assign bus.halted      = (state_q == HALTED);
  assign state_dbg       = state_q;

`ifdef FETCH_PERF_EN
  logic stall_now;
  assign stall_now = ((state_q == REQ) && !bus.imem_ack) ||
                     ((state_q == HOLD) && !bus.instr_ready);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if ((state_q == REQ) && bus.imem_ack && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
      if (stall_now && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// instruction streams checked against a PC/handshake reference model.
module tb_fetch_sequencer;
  localparam int              WORD     = 64;
  localparam int              IL       = 32;
  localparam logic [WORD-1:0] RESET_PC = 64'h0;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_cycles;
`endif

  fetch_sequencer_if #(.WORD(WORD), .INSTR_LEN(IL)) bus ();

  fetch_sequencer #(.WORD(WORD), .INSTR_LEN(IL), .RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count  (fetch_count),
    .stall_cycles (stall_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [WORD-1:0] model_pc;
  logic [WORD-1:0] exp_q[$];

  typedef struct {
    logic [WORD-1:0] addr;
    int              req_cycles;
    logic            addr_stable;
    logic [IL-1:0]   sent;
    int              hold_cycles;
    logic            hold_stable;
    logic            busy_in_exec;
    logic [WORD-1:0] pc_after;
    logic            align_seen;
    int              start_cyc;
  } obs_t;

  // Expected PC after a retire, straight from the architectural rule.
  function automatic logic [WORD-1:0] next_pc_of(input logic [WORD-1:0] pc,
                                                 input logic src,
                                                 input logic [WORD-1:0] tgt);
    logic [WORD-1:0] r;
    if (src) r = (tgt / 4) * 4;
    else     r = pc + 64'd4;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset             = 1'b1;
    bus.halt          = 1'b0;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
    bus.instr_ready   = 1'b0;
    bus.retire        = 1'b0;
    bus.pc_src        = 1'b0;
    bus.branch_target = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    reset    = 1'b0;
    model_pc = RESET_PC;
  endtask

  // Drives one full instruction lifetime; called on a negedge, returns on the
  // negedge following the retire edge. Delays count cycles spent waiting.
  task automatic do_instr(input int ack_dly, input int ready_dly, input int ret_dly,
                          input logic src, input logic [WORD-1:0] tgt,
                          input logic hlt, input logic junk, output obs_t o);
    int n;
    o.addr = 'x; o.req_cycles = 0; o.addr_stable = 1'b1; o.sent = $urandom;
    o.hold_cycles = 0; o.hold_stable = 1'b1; o.busy_in_exec = 1'b0;
    o.pc_after = 'x; o.align_seen = 1'bx; o.start_cyc = cyc;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.imem_req !== 1'b1) return;
    o.start_cyc = cyc;
    o.addr      = bus.imem_addr;
    n = 0;
    while (bus.imem_req === 1'b1 && n < 40) begin
      if (bus.imem_addr !== o.addr) o.addr_stable = 1'b0;
      bus.imem_ack   = (n == ack_dly);
      bus.imem_rdata = (n == ack_dly) ? o.sent : IL'($urandom);
      if (junk) begin
        bus.instr_ready   = 1'($urandom);
        bus.retire        = 1'($urandom);
        bus.pc_src        = 1'($urandom);
        bus.branch_target = {$urandom, $urandom};
      end
      @(negedge clk);
      n++;
      o.req_cycles++;
    end
    bus.imem_ack = 1'b0;
    n = 0;
    while (bus.instr_valid === 1'b1 && n < 40) begin
      if (bus.instruction !== o.sent || bus.cur_pc !== o.addr) o.hold_stable = 1'b0;
      bus.instr_ready = (n == ready_dly);
      if (junk) begin
        bus.imem_ack   = 1'($urandom);
        bus.imem_rdata = $urandom;
        bus.retire     = 1'($urandom);
        bus.pc_src     = 1'($urandom);
      end
      @(negedge clk);
      n++;
      o.hold_cycles++;
    end
    bus.instr_ready = 1'b0;
    bus.retire      = 1'b0;
    for (int i = 0; i <= ret_dly; i++) begin
      if (bus.imem_req === 1'b1 || bus.instr_valid === 1'b1) o.busy_in_exec = 1'b1;
      if (i == ret_dly) begin
        bus.retire        = 1'b1;
        bus.pc_src        = src;
        bus.branch_target = tgt;
        bus.halt          = hlt;
      end else if (junk) begin
        bus.imem_ack    = 1'($urandom);
        bus.instr_ready = 1'($urandom);
        bus.halt        = 1'($urandom);
      end
      @(negedge clk);
    end
    bus.retire        = 1'b0;
    bus.imem_ack      = 1'b0;
    bus.instr_ready   = 1'b0;
    bus.pc_src        = 1'($urandom);
    bus.branch_target = {$urandom, $urandom};
    o.pc_after   = bus.cur_pc;
    o.align_seen = bus.align_err;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total += 6;
    if (bus.imem_req !== 1'b0)    begin bad++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
    if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
    if (bus.align_err !== 1'b0)   begin bad++; $display("FAIL reset_align: got %b expected 0", bus.align_err); end
    if (bus.halted !== 1'b0)      begin bad++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
    if (bus.cur_pc !== RESET_PC)  begin bad++; $display("FAIL reset_pc: got %0h expected %0h", bus.cur_pc, RESET_PC); end
    if (bus.instruction !== '0)   begin bad++; $display("FAIL reset_instr: got %0h expected 0", bus.instruction); end
    release_reset();
    @(negedge clk);
    total++;
    if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL idle_to_req: got %b expected 1", bus.imem_req); end
  endtask

  task automatic test_sequential();
    obs_t o;
    int   prev;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      do_instr(0, 0, 0, 1'b0, '0, 1'b0, 1'b0, o);
      total += 3;
      if (o.addr !== model_pc) begin bad++; $display("FAIL seq_addr[%0d]: got %0h expected %0h", i, o.addr, model_pc); end
      if (o.hold_cycles != 1)  begin bad++; $display("FAIL seq_valid_cycles[%0d]: got %0d expected 1", i, o.hold_cycles); end
      if (o.pc_after !== next_pc_of(model_pc, 1'b0, '0)) begin
        bad++; $display("FAIL seq_pc_after[%0d]: got %0h expected %0h", i, o.pc_after, next_pc_of(model_pc, 1'b0, '0));
      end
      if (i > 0) begin
        total++;
        if (o.start_cyc - prev != 3) begin bad++; $display("FAIL seq_period[%0d]: got %0d expected 3", i, o.start_cyc - prev); end
      end
      prev     = o.start_cyc;
      model_pc = next_pc_of(model_pc, 1'b0, '0);
    end
  endtask

  task automatic test_branch();
    obs_t            o;
    logic [WORD-1:0] want[4];
    logic            srcs[4];
    want = '{64'd0, 64'd4, 64'd36, 64'd40};
    srcs = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    release_reset();
    for (int i = 0; i < 4; i++) begin
      do_instr(0, 0, 0, srcs[i], 64'd36, 1'b0, 1'b0, o);
      total++;
      if (o.addr !== want[i]) begin bad++; $display("FAIL branch_addr[%0d]: got %0h expected %0h", i, o.addr, want[i]); end
      model_pc = next_pc_of(model_pc, srcs[i], 64'd36);
    end
  endtask

  task automatic test_delays();
    obs_t o;
    do_reset();
    release_reset();
    do_instr(3, 2, 1, 1'b0, '0, 1'b0, 1'b0, o);
    total += 6;
    if (o.addr !== RESET_PC)  begin bad++; $display("FAIL delay_addr: got %0h expected %0h", o.addr, RESET_PC); end
    if (o.req_cycles != 4)    begin bad++; $display("FAIL delay_req_cycles: got %0d expected 4", o.req_cycles); end
    if (o.addr_stable !== 1)  begin bad++; $display("FAIL delay_addr_stable: got %b expected 1", o.addr_stable); end
    if (o.hold_cycles != 3)   begin bad++; $display("FAIL delay_hold_cycles: got %0d expected 3", o.hold_cycles); end
    if (o.hold_stable !== 1)  begin bad++; $display("FAIL delay_hold_stable: got %b expected 1", o.hold_stable); end
    if (o.busy_in_exec !== 0) begin bad++; $display("FAIL delay_exec_idle: got %b expected 0", o.busy_in_exec); end
`ifdef FETCH_PERF_EN
    total += 2;
    if (stall_cycles !== 32'd5) begin bad++; $display("FAIL perf_stall: got %0d expected 5", stall_cycles); end
    if (fetch_count !== 32'd1)  begin bad++; $display("FAIL perf_fetch: got %0d expected 1", fetch_count); end
`endif
    model_pc = next_pc_of(model_pc, 1'b0, '0);
  endtask

  task automatic test_align();
    obs_t o;
    do_instr(0, 0, 0, 1'b1, 64'h26, 1'b0, 1'b0, o);
    total += 3;
    if (o.addr !== model_pc)     begin bad++; $display("FAIL align_addr: got %0h expected %0h", o.addr, model_pc); end
    if (o.pc_after !== 64'h24)   begin bad++; $display("FAIL align_pc: got %0h expected 24", o.pc_after); end
    if (o.align_seen !== 1'b1)   begin bad++; $display("FAIL align_pulse: got %b expected 1", o.align_seen); end
    @(negedge clk);
    total++;
    if (bus.align_err !== 1'b0)  begin bad++; $display("FAIL align_one_cycle: got %b expected 0", bus.align_err); end
    model_pc = 64'h24;
  endtask

  task automatic test_wrap();
    obs_t o;
    do_instr(0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, o);
    total += 2;
    if (o.pc_after !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_setup: got %0h expected fffffffffffffffc", o.pc_after); end
    if (o.align_seen !== 1'b0)  begin bad++; $display("FAIL wrap_no_align: got %b expected 0", o.align_seen); end
    model_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    do_instr(0, 0, 0, 1'b0, '0, 1'b0, 1'b0, o);
    total += 2;
    if (o.addr !== model_pc)    begin bad++; $display("FAIL wrap_addr: got %0h expected %0h", o.addr, model_pc); end
    if (o.pc_after !== 64'h0)   begin bad++; $display("FAIL wrap_pc: got %0h expected 0", o.pc_after); end
    model_pc = 64'h0;
    do_instr(0, 0, 0, 1'b0, '0, 1'b0, 1'b0, o);
    total++;
    if (o.addr !== 64'h0)       begin bad++; $display("FAIL wrap_fetch0: got %0h expected 0", o.addr); end
    model_pc = 64'h4;
  endtask

  task automatic test_random();
    obs_t            o;
    int              ad, rd, td;
    logic            src;
    logic [WORD-1:0] tgt, want_pc, want_addr;
    exp_q.delete();
    exp_q.push_back(model_pc);
    for (int i = 0; i < 30; i++) begin
      ad  = $urandom_range(0, 3);
      rd  = $urandom_range(0, 3);
      td  = $urandom_range(0, 3);
      src = 1'($urandom);
      tgt = {$urandom, $urandom};
      do_instr(ad, rd, td, src, tgt, 1'b0, 1'b1, o);
      want_addr = exp_q.pop_front();
      want_pc   = next_pc_of(want_addr, src, tgt);
      exp_q.push_back(want_pc);
      total += 8;
      if (o.addr !== want_addr)        begin bad++; $display("FAIL rnd_addr[%0d]: got %0h expected %0h", i, o.addr, want_addr); end
      if (o.req_cycles != ad + 1)      begin bad++; $display("FAIL rnd_req_cycles[%0d]: got %0d expected %0d", i, o.req_cycles, ad + 1); end
      if (o.hold_cycles != rd + 1)     begin bad++; $display("FAIL rnd_hold_cycles[%0d]: got %0d expected %0d", i, o.hold_cycles, rd + 1); end
      if (o.addr_stable !== 1'b1)      begin bad++; $display("FAIL rnd_addr_stable[%0d]: got %b expected 1", i, o.addr_stable); end
      if (o.hold_stable !== 1'b1)      begin bad++; $display("FAIL rnd_hold_stable[%0d]: got %b expected 1", i, o.hold_stable); end
      if (o.busy_in_exec !== 1'b0)     begin bad++; $display("FAIL rnd_exec_idle[%0d]: got %b expected 0", i, o.busy_in_exec); end
      if (o.pc_after !== want_pc)      begin bad++; $display("FAIL rnd_pc[%0d]: got %0h expected %0h", i, o.pc_after, want_pc); end
      if (o.align_seen !== (src && (tgt % 4 != 0))) begin
        bad++; $display("FAIL rnd_align[%0d]: got %b expected %b", i, o.align_seen, src && (tgt % 4 != 0));
      end
    end
    model_pc = exp_q.pop_front();
  endtask

  task automatic test_halt();
    obs_t            o;
    logic [WORD-1:0] tgt, want_pc;
    int              reqs;
    tgt     = {$urandom, $urandom};
    want_pc = next_pc_of(model_pc, 1'b1, tgt);
    do_instr(0, 0, 2, 1'b1, tgt, 1'b1, 1'b0, o);
    total += 2;
    if (o.pc_after !== want_pc) begin bad++; $display("FAIL halt_pc: got %0h expected %0h", o.pc_after, want_pc); end
    if (bus.halted !== 1'b1)    begin bad++; $display("FAIL halt_flag: got %b expected 1", bus.halted); end
    bus.halt = 1'b0;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      bus.imem_ack    = 1'($urandom);
      bus.instr_ready = 1'($urandom);
      bus.retire      = 1'($urandom);
      @(negedge clk);
      if (bus.imem_req === 1'b1) reqs++;
    end
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b0; bus.retire = 1'b0;
    total += 3;
    if (reqs != 0)              begin bad++; $display("FAIL halt_no_req: got %0d expected 0", reqs); end
    if (bus.halted !== 1'b1)    begin bad++; $display("FAIL halt_sticky: got %b expected 1", bus.halted); end
    if (bus.cur_pc !== want_pc) begin bad++; $display("FAIL halt_pc_hold: got %0h expected %0h", bus.cur_pc, want_pc); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    release_reset();
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rmid_req_timeout: got %b expected 1", bus.imem_req); end
    reset          = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    reset        = 1'b0;
    total += 5;
    if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b expected 0", bus.instr_valid); end
    if (bus.imem_req !== 1'b0)    begin bad++; $display("FAIL rmid_req: got %b expected 0", bus.imem_req); end
    if (bus.cur_pc !== RESET_PC)  begin bad++; $display("FAIL rmid_pc: got %0h expected %0h", bus.cur_pc, RESET_PC); end
    if (bus.instruction !== '0)   begin bad++; $display("FAIL rmid_instr: got %0h expected 0", bus.instruction); end
    if (bus.halted !== 1'b0)      begin bad++; $display("FAIL rmid_halted: got %b expected 0", bus.halted); end
    @(negedge clk);
    total += 2;
    if (bus.imem_req !== 1'b1)      begin bad++; $display("FAIL rmid_refetch: got %b expected 1", bus.imem_req); end
    if (bus.imem_addr !== RESET_PC) begin bad++; $display("FAIL rmid_addr: got %0h expected %0h", bus.imem_addr, RESET_PC); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_delays();
    test_align();
    test_wrap();
    test_random();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle controller that owns the program counter and sequences instruction fetch for the nonpipelined LEGv8 core.
- Issues one request at a time to instruction memory and holds the returned instruction for decode until it is accepted.
- Waits for the retire/branch-resolution result before computing the next PC (pc_src ? branch_target : PC+4).
- Sits between instruction memory and the decode/execute control path.

Parameters:
WORD, 64, PC and branch target width in bits
INSTR_LEN, 32, instruction width in bits
RESET_PC, 0, PC value loaded on reset (must be a multiple of 4)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
halt  input  1  level; stop issuing new fetches once the current instruction retires
imem_req  output  1  fetch request to instruction memory
imem_addr  output  WORD  fetch address (equals cur_pc)
imem_ack  input  1  memory has returned data this cycle
imem_rdata  input  INSTR_LEN  returned instruction word
instr_valid  output  1  instruction and cur_pc are valid for decode
instr_ready  input  1  decode accepts the instruction
instruction  output  INSTR_LEN  registered instruction
cur_pc  output  WORD  PC of the current instruction
retire  input  1  current instruction has completed; pc_src and branch_target are valid
pc_src  input  1  1 = take branch_target, 0 = sequential
branch_target  input  WORD  redirect address
align_err  output  1  one-cycle pulse when a misaligned branch_target is retired
halted  output  1  controller is in HALTED

Behaviour:
- Reset, applied synchronously at the next clk edge:
  - state=IDLE, cur_pc=RESET_PC, instruction=0.
  - imem_req=0, instr_valid=0, align_err=0, halted=0.
  - Reset overrides every other input in that cycle, including mid-request. An imem_ack arriving in the reset cycle is discarded.
- States:
  - IDLE: one cycle after reset deassert; goes to REQ, or to HALTED if halt=1.
  - REQ: imem_req=1, imem_addr=cur_pc.
    - On imem_ack: capture imem_rdata into instruction, go to HOLD.
    - With ack in the first REQ cycle, instr_valid rises exactly one cycle after imem_req rises.
    - imem_req stays high until ack; there is no timeout.
  - HOLD: instr_valid=1, instruction and cur_pc stable. On instr_ready, go to EXEC.
  - EXEC: instr_valid=0, imem_req=0; wait for retire.
    - On retire: next_pc = pc_src ? {branch_target[WORD-1:2],2'b00} : cur_pc+4, computed modulo 2^WORD (wraps from 2^WORD-4 to 0).
    - If pc_src=1 and branch_target[1:0]!=0, pulse align_err in the cycle after retire.
    - Load next_pc into cur_pc and go to REQ, or to HALTED if halt=1 in the retire cycle.
  - HALTED: halted=1, no requests, cur_pc holds next_pc. Leave only via reset.
- Inputs outside their state are ignored:
  - imem_ack outside REQ.
  - instr_ready outside HOLD.
  - retire outside EXEC.
- Halt sampling: halt is sampled only in IDLE and at retire. Asserting halt during REQ or HOLD does not abort the in-flight instruction.
- Simultaneous events:
  - retire+halt: PC updates and the state goes to HALTED.
  - retire+pc_src with a misaligned target: redirect to the aligned target, plus align_err.
- pc_src and branch_target are don't-care when retire=0.
- Minimum period per instruction, with ack, ready and retire each on their first possible cycle: 3 cycles (REQ, HOLD, EXEC).

Optional Feature:
FETCH_PERF_EN
- Defined: adds output ports fetch_count[31:0] and stall_cycles[31:0].
  - fetch_count increments on each imem_ack accepted in REQ.
  - stall_cycles increments on every REQ cycle without ack and every HOLD cycle without instr_ready.
  - Both clear on reset and saturate at 0xFFFFFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset then ack, ready and retire (pc_src=0) immediate, three instructions -> imem_addr sequence 0,4,8; instr_valid high one cycle per instruction; 3 cycles per instruction.
- After the fetch at PC 4, retire with pc_src=1, branch_target=36 -> next imem_addr=36; then retire with pc_src=0 -> imem_addr=40.
- imem_ack delayed 3 cycles and instr_ready delayed 2 cycles -> imem_req held 4 cycles with addr stable; instruction and cur_pc stable throughout HOLD; FETCH_PERF_EN: stall_cycles=5, fetch_count=1.
- Retire with pc_src=1, branch_target=0x26 -> cur_pc=0x24, align_err one-cycle pulse.
- cur_pc=0xFFFF_FFFF_FFFF_FFFC, retire with pc_src=0 -> imem_addr=0.
- Two cases:
  - halt with retire -> halted=1, imem_req never rises again.
  - reset asserted during REQ with a simultaneous ack -> next cycle state=IDLE, instr_valid=0, cur_pc=RESET_PC.
